// File: rtl/decode_stage.sv
// Decode stage: register file, load-use hazard detection and the D-to-E register.
// Define DECODE_BYPASS_EN for write-through reads from the writeback port.
module decode_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  instr_D,
  input  logic [CTRL_W-1:0] ctrl_D,
  input  logic              memRead_D,
  input  logic [WIDTH-1:0]  immExt_D,
  input  logic [WIDTH-1:0]  pc_D,
  input  logic              regWrite_W,
  input  logic [4:0]        Rd_W,
  input  logic [WIDTH-1:0]  result_W,
  input  logic              flush_E,
  output logic              stall_D,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic              memRead_E,
  output logic [WIDTH-1:0]  RD1_E,
  output logic [WIDTH-1:0]  RD2_E,
  output logic [WIDTH-1:0]  immExt_E,
  output logic [WIDTH-1:0]  pc_E,
  output logic [4:0]        Rs1_E,
  output logic [4:0]        Rs2_E,
  output logic [4:0]        Rd_E,
  output logic [WIDTH-1:0]  a0
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [WIDTH-1:0] regs [NREG];
  logic [4:0]       rs1, rs2, rd;
  logic [WIDTH-1:0] rd1, rd2;
  logic             wr_en;
  logic             lu_hz;
  logic             wb_hz;
  logic             bubble;
  logic             unused_instr;

  assign rs1 = instr_D[19:15];
  assign rs2 = instr_D[24:20];
  assign rd  = instr_D[11:7];
  assign unused_instr = ^{instr_D[WIDTH-1:25], instr_D[6:0]};

  assign wr_en = regWrite_W && (Rd_W != 5'd0)
              && (int'(Rd_W) < NREG);

  function automatic logic [WIDTH-1:0] rf_read(input logic [4:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (a != 5'd0 && int'(a) < NREG) begin
      v = regs[a[REG_ADDR_W-1:0]];
`ifdef DECODE_BYPASS_EN
      if (regWrite_W && Rd_W == a)
        v = result_W;
`endif
    end
    return v;
  endfunction

  assign rd1 = rf_read(rs1);
  assign rd2 = rf_read(rs2);
  assign a0  = regs[10];

  assign lu_hz = memRead_E && (Rd_E != 5'd0)
              && ((Rd_E == rs1) || (Rd_E == rs2));

`ifdef DECODE_BYPASS_EN
  assign wb_hz = 1'b0;
`else
  // Without write-through, hold D one cycle so the write lands first.
  assign wb_hz = regWrite_W && (Rd_W != 5'd0)
              && ((Rd_W == rs1) || (Rd_W == rs2));
`endif

  assign stall_D = lu_hz || wb_hz;
  assign bubble  = stall_D || flush_E;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[Rd_W[REG_ADDR_W-1:0]] <= result_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ctrl_E    <= '0;
      memRead_E <= 1'b0;
      RD1_E     <= '0;
      RD2_E     <= '0;
      immExt_E  <= '0;
      pc_E      <= '0;
      Rs1_E     <= '0;
      Rs2_E     <= '0;
      Rd_E      <= '0;
    end else begin
      ctrl_E    <= ctrl_D;
      memRead_E <= memRead_D;
      RD1_E     <= rd1;
      RD2_E     <= rd2;
      immExt_E  <= immExt_D;
      pc_E      <= pc_D;
      Rs1_E     <= rs1;
      Rs2_E     <= rs2;
      Rd_E      <= rd;
    end
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width.
REQ-002 The block SHALL have parameter REG_ADDR_W, default 5, register-file address width: 5 = 32 registers, 4 = 16 registers (RV32E).
REQ-003 The block SHALL have parameter CTRL_W, default 16, width of the opaque control bundle.
Ports:
REQ-004 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port instr_D, input, WIDTH, decode-stage instruction; rs1 = [19:15], rs2 = [24:20], rd = [11:7].
REQ-007 The block SHALL have port ctrl_D, input, CTRL_W, control bundle from the control unit.
REQ-008 The block SHALL have port memRead_D, input, 1, the D instruction is a load.
REQ-009 The block SHALL have ports immExt_D and pc_D, input, WIDTH each, extended immediate and PC.
REQ-010 The block SHALL have ports regWrite_W (input, 1), Rd_W (input, 5) and result_W (input, WIDTH), the writeback port.
REQ-011 The block SHALL have port flush_E, input, 1, squash the instruction entering E.
REQ-012 The block SHALL have port stall_D, output, 1, hold F/D; a bubble is entering E.
REQ-013 The block SHALL have ports ctrl_E (output, CTRL_W) and memRead_E (output, 1), registered control.
REQ-014 The block SHALL have ports RD1_E, RD2_E, immExt_E and pc_E, output, WIDTH each, registered operands.
REQ-015 The block SHALL have ports Rs1_E, Rs2_E and Rd_E, output, 5 each, registered register numbers.
REQ-016 The block SHALL have port a0, output, WIDTH, combinational view of register x10.

Function
REQ-017 The register file SHALL hold 2^REG_ADDR_W entries, written on the rising clk edge when regWrite_W = 1 and Rd_W != 0.
REQ-018 Register numbers >= 2^REG_ADDR_W SHALL read as zero, and writes to them SHALL be ignored.
REQ-019 Register x0 SHALL always read zero.
REQ-020 Register reads SHALL be combinational from rs1/rs2.
REQ-021 Load-use hazard: stall_D SHALL be 1 when memRead_E = 1, Rd_E != 0, and Rd_E equals rs1 or rs2 of instr_D; this check SHALL use the full 5-bit comparison.
REQ-022 The D-to-E register SHALL update on every rising edge; latency D to E SHALL be exactly 1 cycle.
REQ-023 When stall_D = 1 or flush_E = 1, E SHALL load a bubble: ctrl_E = 0, memRead_E = 0, Rd_E = 0, Rs1_E = 0, Rs2_E = 0, and all other E outputs = 0.
REQ-024 flush_E SHALL take priority over stall_D, producing the same bubble, and SHALL NOT mask the stall_D output.
REQ-025 Otherwise E SHALL capture the D-stage values, with RD1_E/RD2_E taken from the register read (or bypass per REQ-031).
REQ-026 A stall SHALL last exactly one cycle per load-use pair, because the bubble clears memRead_E.
REQ-027 Simultaneous writeback to x0 SHALL NOT bypass and SHALL NOT alter x0.

Reset
REQ-028 When rst = 1 at a rising edge, all register-file entries SHALL be cleared to 0.
REQ-029 When rst = 1 at a rising edge, all E outputs SHALL be cleared to 0; stall_D and a0 SHALL therefore read 0 the cycle after reset.
REQ-030 Reset SHALL take precedence over writeback, stall and flush in the same cycle.

Configuration
REQ-031 With macro DECODE_BYPASS_EN defined, a read of rs = Rd_W (nonzero, in range) while regWrite_W = 1 SHALL return result_W in the same cycle (write-through).
REQ-032 With DECODE_BYPASS_EN undefined, reads SHALL return the stored value, and stall_D SHALL additionally assert when regWrite_W = 1, Rd_W != 0, and Rd_W matches rs1 or rs2, giving one bubble.

Verification
REQ-033 Scenario write/read: write x5 = 0x1234 via W, then decode add rs1 = x5 -> RD1_E = 0x1234 one cycle later.
REQ-034 Scenario load-use: lw x6 in E, then D has rs2 = x6 -> stall_D = 1 for exactly 1 cycle, ctrl_E = 0 next cycle, and the instruction then enters E.
REQ-035 Scenario flush with stall: flush_E = 1 together with a load-use stall -> bubble in E, with stall_D still 1 that cycle.
REQ-036 Scenario same-cycle writeback: W writes x7 = 0xAA while D reads x7 -> with DECODE_BYPASS_EN, RD1_E = 0xAA with no stall; without it, one stall and then RD1_E = 0xAA.
REQ-037 Scenario RV32E: with REG_ADDR_W = 4, a write to x20 is ignored, a read of x20 returns 0, and a write to x10 = 7 gives a0 = 7.
REQ-038 Scenario mid-operation reset: assert rst during a stall -> all outputs 0 next cycle, and a later read of x5 returns 0.
